instruction_memory: RTL and testbench

Instruction store for the CPU fetch stage: a 32-word × 32-bit register-file memory with one shared address port. Words are written synchronously on the single clock and read combinationally, so the fetch stage sees the addressed instruction within the same cycle. The loader/debug path writes program words through the same port. A synchronous reset clears the whole array to zero.

---
 rtl/instr_mem_pkg.sv | 9 +
 rtl/instr_mem_parity.sv | 13 +
 rtl/instruction_memory.sv | 55 +++++
 tb/tb_instruction_memory.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and types for the fetch-stage instruction store.
package instr_mem_pkg;
    localparam int INSTR_DATA_W = 32;
    localparam int INSTR_ADDR_W = 5;
    localparam int INSTR_DEPTH  = 32;

    typedef logic [INSTR_DATA_W-1:0] instr_word_t;
    typedef logic [INSTR_ADDR_W-1:0] instr_addr_t;
endpackage

// File: rtl/instr_mem_parity.sv
// Even-parity generator for write data and checker for the addressed read word.
module instr_mem_parity #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_parity,
    output logic              wr_parity,
    output logic              parity_err
);
    assign wr_parity  = ^wr_data;
    assign parity_err = ^{rd_data, rd_parity};
endmodule

// File: rtl/instruction_memory.sv
// 32x32 register-file instruction store: synchronous write, combinational read.
// Optional stored even parity with o_parity_err when INSTR_MEM_PARITY_EN is defined.
module instruction_memory
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = INSTR_DATA_W,
    parameter int ADDR_W = INSTR_ADDR_W,
    parameter int DEPTH  = INSTR_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
`ifdef INSTR_MEM_PARITY_EN
    ,
    output logic              o_parity_err
`endif
);
    logic [DATA_W-1:0] mem [DEPTH];

    // An unknown enable falls to the non-write branch, so memory is never corrupted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            assert (!$isunknown(i_wr_en));
            if (i_wr_en == 1'b1) mem[i_addr] <= i_data;
        end
    end

    assign o_data = mem[i_addr];

`ifdef INSTR_MEM_PARITY_EN
    logic parity_mem [DEPTH];
    logic wr_parity;

    instr_mem_parity #(.DATA_W(DATA_W)) u_parity (
        .wr_data    (i_data),
        .rd_data    (mem[i_addr]),
        .rd_parity  (parity_mem[i_addr]),
        .wr_parity  (wr_parity),
        .parity_err (o_parity_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) parity_mem[i] <= 1'b0;
        end else if (i_wr_en == 1'b1) begin
            parity_mem[i_addr] <= wr_parity;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed plan plus random traffic vs. an array model.
module tb_instruction_memory;
    import instr_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    instr_addr_t addr;
    logic        wr_en;
    instr_word_t wdata;
    instr_word_t rdata;
`ifdef INSTR_MEM_PARITY_EN
    logic        perr;
`endif

    instr_word_t model [INSTR_DEPTH];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_memory dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (addr),
        .i_wr_en      (wr_en),
        .i_data       (wdata),
        .o_data       (rdata)
`ifdef INSTR_MEM_PARITY_EN
        ,
        .o_parity_err (perr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check old word before the edge, new word after it.
    task automatic cycle(input logic r, input logic we, input instr_addr_t a, input instr_word_t d,
                         input string tag);
        @(negedge clk);
        rst = r; wr_en = we; addr = a; wdata = d;
        #1;
        chk({tag, "_pre"}, rdata, model[a]);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < INSTR_DEPTH; i++) model[i] = '0;
        end else if (we) begin
            model[a] = d;
        end
        #1;
        chk({tag, "_post"}, rdata, model[a]);
    endtask

    task automatic rd(input instr_addr_t a, input instr_word_t exp, input string tag);
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0;
        @(posedge clk);
        for (int i = 0; i < INSTR_DEPTH; i++) model[i] = '0;
        #1;

        for (int i = 0; i < INSTR_DEPTH; i++) rd(instr_addr_t'(i), 32'h0, "reset_sweep");

        cycle(1'b0, 1'b1, 5'd1, 32'h12345678, "wr_a1");
        rd(5'd1, 32'h12345678, "rd_a1");
        cycle(1'b0, 1'b1, 5'd2, 32'h87654321, "wr_a2");
        rd(5'd2, 32'h87654321, "rd_a2");
        rd(5'd1, 32'h12345678, "rd_a1_again");

        cycle(1'b0, 1'b0, 5'd3, 32'hDEADBEEF, "noen_a3");
        rd(5'd3, 32'h0, "rd_a3_unwritten");

        cycle(1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, "rst_prio");
        rd(5'd5, 32'h0, "rd_a5_after_rst");
        rd(5'd1, 32'h0, "rd_a1_after_rst");
        rd(5'd2, 32'h0, "rd_a2_after_rst");

        cycle(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, "wr_a31");
        cycle(1'b0, 1'b1, 5'd0, 32'h00000001, "wr_a0");
        rd(5'd31, 32'hFFFFFFFF, "rd_a31");
        rd(5'd0, 32'h00000001, "rd_a0");
        for (int i = 1; i < 31; i++) rd(instr_addr_t'(i), 32'h0, "untouched");

        // Reset in the middle of a write burst, then writes resume.
        cycle(1'b0, 1'b1, 5'd10, 32'h11111111, "burst0");
        cycle(1'b1, 1'b1, 5'd11, 32'h22222222, "burst_rst");
        cycle(1'b0, 1'b1, 5'd12, 32'h33333333, "burst1");
        rd(5'd10, 32'h0, "burst_a10");
        rd(5'd11, 32'h0, "burst_a11");
        rd(5'd12, 32'h33333333, "burst_a12");

        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1,
                  instr_addr_t'($urandom_range(0, INSTR_DEPTH - 1)), $urandom, "rand");
            begin
                instr_addr_t ra;
                ra = instr_addr_t'($urandom_range(0, INSTR_DEPTH - 1));
                rd(ra, model[ra], "rand_rd");
            end
        end

`ifdef INSTR_MEM_PARITY_EN
        cycle(1'b0, 1'b1, 5'd7, 32'h0000_0007, "par_wr7");
        cycle(1'b0, 1'b1, 5'd8, 32'hC000_0001, "par_wr8");
        @(negedge clk); addr = 5'd7; wr_en = 1'b0; #1;
        chk("parity_ok7", {31'd0, perr}, 32'd0);
        addr = 5'd8; #1;
        chk("parity_ok8", {31'd0, perr}, 32'd0);
        dut.mem[7][3] = ~dut.mem[7][3];
        addr = 5'd7; #1;
        chk("parity_err7", {31'd0, perr}, 32'd1);
        addr = 5'd8; #1;
        chk("parity_ok8_after_flip", {31'd0, perr}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
